// File: rtl/load_store_ctrl_if.sv
// Pipeline request/response and data-bus signals of the load/store unit.
// The slave modport is the controller; master is the pipeline plus bus.
interface load_store_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        adel;
  logic        ades;
  logic [31:0] bad_addr;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, flush,
    output bus_ack, bus_rdata,
    input  stall, resp_valid, resp_data, adel, ades, bad_addr,
    input  bus_req, bus_wr, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, flush,
    input  bus_ack, bus_rdata,
    output stall, resp_valid, resp_data, adel, ades, bad_addr,
    output bus_req, bus_wr, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/load_store_ctrl.sv
// MEM-stage load/store controller: alignment check, byte lanes,
// single-outstanding bus transaction and load extension.
module load_store_ctrl (
  input logic              clk,
  input logic              resetn,
  load_store_ctrl_if.slave lsu
);

  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_e;

  state_e      state_q, state_d;
  logic        kill_q, kill_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_wr_q, bus_wr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        adel_q, adel_d;
  logic        ades_q, ades_d;
  logic [31:0] bad_addr_q, bad_addr_d;

  logic        is_st;
  logic        is_sh;
  logic        is_sb;
  logic        mis;
  logic [3:0]  be;
  logic [31:0] wd;

  function automatic logic [31:0] ld_ext(
    input logic [2:0]  op,
    input logic [1:0]  off,
    input logic [31:0] rd
  );
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? rd[31:16] : rd[15:0];
    b = rd[{off, 3'b000} +: 8];
    case (op)
      3'b000:  ld_ext = rd;
      3'b001:  ld_ext = {{16{h[15]}}, h};
      3'b010:  ld_ext = {16'h0, h};
      3'b011:  ld_ext = {{24{b[7]}}, b};
      3'b100:  ld_ext = {24'h0, b};
      default: ld_ext = '0;
    endcase
  endfunction

  always_comb begin
    is_sh = lsu.req_op == 3'b110;
    is_sb = lsu.req_op == 3'b111;
    is_st = lsu.req_op == 3'b101 || is_sh || is_sb;
    case (lsu.req_op)
      3'b000, 3'b101:         mis = |lsu.req_addr[1:0];
      3'b001, 3'b010, 3'b110: mis = lsu.req_addr[0];
      default:                mis = 1'b0;
    endcase
    be = 4'b1111;
    wd = lsu.req_wdata;
    unique case (1'b1)
      is_sh: begin
        be = lsu.req_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{lsu.req_wdata[15:0]}};
      end
      is_sb: begin
        be = 4'b0001 << lsu.req_addr[1:0];
        wd = {4{lsu.req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    op_d         = op_q;
    off_d        = off_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    adel_d       = 1'b0;
    ades_d       = 1'b0;
    bad_addr_d   = bad_addr_q;
    unique case (state_q)
      IDLE: begin
        if (lsu.req_valid && !lsu.flush) begin
          kill_d = 1'b0;
          op_d   = lsu.req_op;
          off_d  = lsu.req_addr[1:0];
          if (mis) begin
            state_d    = ERR;
            adel_d     = !is_st;
            ades_d     = is_st;
            bad_addr_d = lsu.req_addr;
          end else begin
            state_d     = BUS;
            bus_req_d   = 1'b1;
            bus_wr_d    = is_st;
            bus_addr_d  = {lsu.req_addr[31:2], 2'b00};
            bus_be_d    = be;
            bus_wdata_d = wd;
          end
        end
      end
      BUS: begin
        // A flush cannot abandon the bus cycle; it only kills the result.
        if (lsu.flush) kill_d = 1'b1;
        if (lsu.bus_ack) begin
          state_d      = DONE;
          bus_req_d    = 1'b0;
          bus_wr_d     = 1'b0;
          resp_valid_d = !(kill_q || lsu.flush);
          resp_data_d  = ld_ext(op_q, off_q, lsu.bus_rdata);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      kill_q       <= 1'b0;
      op_q         <= '0;
      off_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      adel_q       <= 1'b0;
      ades_q       <= 1'b0;
      bad_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      op_q         <= op_d;
      off_q        <= off_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      adel_q       <= adel_d;
      ades_q       <= ades_d;
      bad_addr_q   <= bad_addr_d;
    end
  end

  // Pulses are registered; a flush landing in DONE/ERR masks them.
  assign lsu.resp_valid = resp_valid_q && !lsu.flush;
  assign lsu.adel       = adel_q && !lsu.flush;
  assign lsu.ades       = ades_q && !lsu.flush;
  assign lsu.resp_data  = resp_data_q;
  assign lsu.bad_addr   = bad_addr_q;
  assign lsu.bus_req    = bus_req_q;
  assign lsu.bus_wr     = bus_wr_q;
  assign lsu.bus_addr   = bus_addr_q;
  assign lsu.bus_be     = bus_be_q;
  assign lsu.bus_wdata  = bus_wdata_q;
  assign lsu.stall      = lsu.req_valid && !lsu.flush &&
                          !(state_q == DONE || state_q == ERR);

endmodule

// File: doc/load_store_ctrl.md
LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 Port: resetn  input  1  synchronous, active-low reset.
REQ-003 Port: req_valid  input  1  MEM stage presents a memory op; held stable until resp_valid, adel/ades, or flush.
REQ-004 Port: req_op  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
REQ-005 Port: req_addr  input  32  byte address (ALU result).
REQ-006 Port: req_wdata  input  32  store source register.
REQ-007 Port: flush  input  1  pipeline flush; kills the current op.
REQ-008 Port: bus_req, bus_wr  output  1 each  bus request; write when 1.
REQ-009 Port: bus_addr  output  32  {req_addr[31:2],2'b00}, registered.
REQ-010 Port: bus_be  output  4  byte strobes, registered.
REQ-011 Port: bus_wdata  output  32  lane-replicated store data, registered.
REQ-012 Port: bus_ack  input  1  completes the request in the cycle it is sampled high with bus_req.
REQ-013 Port: bus_rdata  input  32  read word, valid with bus_ack.
REQ-014 Port: stall  output  1  freezes the pipeline.
REQ-015 Port: resp_valid  output  1  one-cycle completion pulse.
REQ-016 Port: resp_data  output  32  aligned, extended load data; 0 for stores.
REQ-017 Port: adel, ades  output  1 each  one-cycle misaligned load / store exception pulse.
REQ-018 Port: bad_addr  output  32  faulting req_addr, valid with adel/ades.

Function
REQ-019 States SHALL be IDLE, BUS, DONE, ERR, encoded in registers.
REQ-020 IDLE with req_valid=1 and flush=0 SHALL accept the op: aligned -> BUS; misaligned -> ERR.
REQ-021 Misaligned SHALL mean addr[1:0]!=0 for lw/sw and addr[0]!=0 for lh/lhu/sh; byte ops are never misaligned.
REQ-022 BUS SHALL hold bus_req=1 with stable bus_wr/addr/be/wdata until bus_ack=1, then go to DONE with bus_rdata captured.
REQ-023 DONE SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-024 ERR SHALL pulse adel (loads) or ades (stores) for one cycle with bad_addr, issue no bus request, then return to IDLE.
REQ-025 Minimum latency: accept at cycle 0, bus_req at cycle 1; ack at cycle 1 gives resp_valid at cycle 2.
REQ-026 stall SHALL equal req_valid & ~flush & ~(state==DONE | state==ERR).
REQ-027 bus_be: loads 1111; sw 1111; sh 0011 if addr[1]=0, else 1100; sb 0001<<addr[1:0].
REQ-028 bus_wdata: sw word; sh {2{wdata[15:0]}}; sb {4{wdata[7:0]}}.
REQ-029 Loads: lh/lhu select halfword by addr[1]; lb/lbu select byte by addr[1:0]; lh/lb sign-extend; lhu/lbu zero-extend.
REQ-030 Flush in IDLE SHALL block acceptance.
REQ-031 Flush in BUS SHALL NOT drop bus_req: the transaction completes and the op is marked killed.
REQ-032 Flush in DONE or ERR, or a killed op, SHALL suppress resp_valid, adel, and ades.
REQ-033 bus_ack outside BUS SHALL be ignored.
REQ-034 A new op SHALL be accepted no earlier than the cycle after DONE or ERR.

Reset
REQ-035 resetn=0 at a clock edge SHALL force IDLE and clear the kill flag.
REQ-036 Reset SHALL clear all registered outputs to 0: bus_req, bus_wr, bus_addr, bus_be, bus_wdata, resp_valid, resp_data, adel, ades, bad_addr.
REQ-037 Reset mid-BUS SHALL deassert bus_req on the following cycle, regardless of bus_ack.

Verification
REQ-038 lb, addr 0x1003, rdata 0x80FF_0000, ack 2 cycles after bus_req -> bus_be 1111, resp_data 0xFFFF_FF80, stall high until resp cycle.
REQ-039 sh, addr 0x2002, wdata 0x1234_ABCD -> bus_addr 0x2000, bus_be 1100, bus_wdata 0xABCD_ABCD, bus_wr 1, resp_data 0.
REQ-040 lw, addr 0x3001 -> no bus_req, adel pulse with bad_addr 0x3001, no resp_valid.
REQ-041 lhu, addr 0x4002, flush in BUS -> bus_req held until ack, resp_valid never asserted, IDLE afterwards.
REQ-042 resetn=0 while bus_req=1 -> bus_req 0 next cycle, all outputs 0, next op accepted normally.
REQ-043 Zero-wait ack on sb, addr 0x5001, wdata 0xAA -> bus_be 0010, resp_valid at cycle 2.
